// File: rtl/count_pkg.sv
// Shared constants and elaboration-time helpers for the count_mod family.
package count_pkg;

   localparam bit DIR_UP    = 1'b1;
   localparam bit DIR_DOWN  = 1'b0;
   localparam bit MODE_WRAP = 1'b0;
   localparam bit MODE_SAT  = 1'b1;

   // Bits needed to hold values 0..value-1.
   function automatic int clog2(input longint unsigned value);
      int bits = 0;
      while ((64'd1 << bits) < value) bits++;
      return bits;
   endfunction

endpackage

// File: rtl/count_prescale.sv
// Enable divider: tick is combinational, high on every PRESCALE-th enabled cycle.
// No backpressure; clear (load) restarts the period on the next edge.
module count_prescale
   import count_pkg::*;
#(
   parameter int PRESCALE = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int            PW   = clog2(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pcnt;

   assign tick = enable && (pcnt == LAST);

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         pcnt <= '0;
      end else if (enable) begin
         pcnt <= (pcnt == LAST) ? '0 : pcnt + PW'(1);
      end
   end

endmodule

// File: rtl/count_mod.sv
// Modulo up/down counter with load, prescaled enable and wrap/saturate ends.
// count updates one edge after tick or load; carry is combinational for cascading.
module count_mod
   import count_pkg::*;
#(
   parameter int                WIDTH    = 16,
   parameter logic [WIDTH-1:0]  INIT     = '0,
   parameter longint unsigned   MODULUS  = 64'd1 << WIDTH,
   parameter int                PRESCALE = 1,
   parameter bit                SATURATE = MODE_WRAP
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             msb,
   output logic             tick,
   output logic             carry
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

   logic             at_term;
   logic [WIDTH-1:0] term_val;
   logic [WIDTH-1:0] wrap_val;
   logic [WIDTH-1:0] clamped;
   logic [WIDTH-1:0] count_next;

   generate
      if (PRESCALE == 1) begin : g_no_pre
         assign tick = enable;
      end else begin : g_pre
         count_prescale #(.PRESCALE(PRESCALE)) u_pre (
            .clock  (clock),
            .reset  (reset),
            .enable (enable),
            .clear  (load),
            .tick   (tick)
         );
      end
   endgenerate

   // Terminal value and wrap target both follow up combinationally.
   assign term_val = (up == DIR_UP)   ? MAX_VAL : '0;
   assign wrap_val = (up == DIR_DOWN) ? MAX_VAL : '0;
   assign at_term  = (count == term_val);
   assign carry    = tick && at_term;
   assign clamped  = (load_value > MAX_VAL) ? MAX_VAL : load_value;
   assign msb      = count[WIDTH-1];

   always_comb begin
      count_next = count;
      if (tick) begin
         if (at_term) begin
            count_next = (SATURATE == MODE_SAT) ? count : wrap_val;
         end else if (up == DIR_UP) begin
            count_next = count + WIDTH'(1);
         end else begin
            count_next = count - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= INIT;
      end else if (load) begin
         count <= clamped;
      end else begin
         count <= count_next;
      end
   end

endmodule

// File: tb/tb_count_mod.sv
// Bench for count_mod: wrap, saturate, prescaled and cascaded instances against
// a behavioural model, plus directed vectors for the corner cases.
module tb_count_mod;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic       up = 1'b1;
   logic       load = 1'b0;
   logic [3:0] load_value = '0;

   logic [4:0][3:0] cnt;
   logic [4:0]      msb_v, tick_v, carry_v;

   int checks = 0;
   int failures = 0;

   // 0: wrap, 1: saturate, 2: prescale 3 (INIT 5), 3: cascade low, 4: cascade high
   int p_mod[5]  = '{10, 10, 10, 10, 10};
   int p_pre[5]  = '{1, 1, 3, 1, 1};
   int p_sat[5]  = '{0, 1, 0, 0, 0};
   int p_init[5] = '{0, 0, 5, 0, 0};

   count_mod #(.WIDTH(4), .INIT(0), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u_a (
      .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load), .load_value(load_value),
      .count(cnt[0]), .msb(msb_v[0]), .tick(tick_v[0]), .carry(carry_v[0]));
   count_mod #(.WIDTH(4), .INIT(0), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) u_b (
      .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load), .load_value(load_value),
      .count(cnt[1]), .msb(msb_v[1]), .tick(tick_v[1]), .carry(carry_v[1]));
   count_mod #(.WIDTH(4), .INIT(5), .MODULUS(10), .PRESCALE(3), .SATURATE(0)) u_c (
      .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load), .load_value(load_value),
      .count(cnt[2]), .msb(msb_v[2]), .tick(tick_v[2]), .carry(carry_v[2]));
   count_mod #(.WIDTH(4), .INIT(0), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u_lo (
      .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load), .load_value(load_value),
      .count(cnt[3]), .msb(msb_v[3]), .tick(tick_v[3]), .carry(carry_v[3]));
   count_mod #(.WIDTH(4), .INIT(0), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u_hi (
      .clock(clock), .reset(reset), .enable(carry_v[3]), .up(up), .load(load), .load_value(load_value),
      .count(cnt[4]), .msb(msb_v[4]), .tick(tick_v[4]), .carry(carry_v[4]));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model state: count value and number of enabled cycles since the last step.
   int m_cnt[5];
   int m_ph[5];
   bit m_valid = 1'b0;

   task automatic model_step();
      bit mtick[5];
      bit mcarry[5];
      bit en_i;
      int term;
      for (int i = 0; i < 5; i++) begin
         en_i      = (i == 4) ? mcarry[3] : enable;
         mtick[i]  = en_i && (((m_ph[i] + 1) % p_pre[i]) == 0);
         term      = up ? p_mod[i] - 1 : 0;
         mcarry[i] = mtick[i] && (m_cnt[i] == term);
         if (m_valid) begin
            chk($sformatf("model_count%0d", i), int'(cnt[i]), m_cnt[i]);
            chk($sformatf("model_msb%0d", i), int'(msb_v[i]), int'(m_cnt[i] >= 8));
            chk($sformatf("model_tick%0d", i), int'(tick_v[i]), int'(mtick[i]));
            chk($sformatf("model_carry%0d", i), int'(carry_v[i]), int'(mcarry[i]));
         end
         if (reset) begin
            m_cnt[i] = p_init[i];
            m_ph[i]  = 0;
         end else if (load) begin
            m_cnt[i] = (int'(load_value) < p_mod[i]) ? int'(load_value) : p_mod[i] - 1;
            m_ph[i]  = 0;
         end else begin
            if (en_i) m_ph[i] = (m_ph[i] + 1) % p_pre[i];
            if (mtick[i] && !(mcarry[i] && p_sat[i] == 1)) begin
               m_cnt[i] = up ? (m_cnt[i] + 1) % p_mod[i]
                             : (m_cnt[i] + p_mod[i] - 1) % p_mod[i];
            end
         end
      end
      if (reset) m_valid = 1'b1;
   endtask

   // Inputs are set just after a falling edge; outputs are sampled 1ns later.
   task automatic finish_cycle();
      model_step();
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b1; enable = 1'b0; load = 1'b0; up = 1'b1; load_value = '0;
      #1;
      finish_cycle();
      reset = 1'b0;
   endtask

   typedef struct {
      bit         rst, en, upd, ld;
      logic [3:0] lv;
      int         ea, eb, ec;
      bit         ca, cb, tc;
   } vec_t;

   function automatic vec_t mk(bit rst, bit en, bit upd, bit ld, logic [3:0] lv,
                               int ea, int eb, int ec, bit ca, bit cb, bit tc);
      vec_t v;
      v.rst = rst; v.en = en; v.upd = upd; v.ld = ld; v.lv = lv;
      v.ea = ea; v.eb = eb; v.ec = ec; v.ca = ca; v.cb = cb; v.tc = tc;
      return v;
   endfunction

   vec_t tbl[21];

   initial begin
      // Count up 0..9,0,1 (wrap), up to 9 and hold (sat), +1 every third cycle (prescale).
      for (int i = 0; i < 12; i++)
         tbl[i] = mk(0, 1, 1, 0, 4'd0, i % 10, (i < 10) ? i : 9, 5 + i / 3,
                     i == 9, i >= 9, (i % 3) == 2);
      // Count down through 0 -> 9; saturated stage leaves 9 on the first down step.
      tbl[12] = mk(0, 1, 0, 0, 4'd0,  2, 9, 9, 0, 0, 0);
      tbl[13] = mk(0, 1, 0, 0, 4'd0,  1, 8, 9, 0, 0, 0);
      tbl[14] = mk(0, 1, 0, 0, 4'd0,  0, 7, 9, 1, 0, 1);
      tbl[15] = mk(0, 1, 0, 0, 4'd0,  9, 6, 8, 0, 0, 0);
      tbl[16] = mk(0, 1, 0, 0, 4'd0,  8, 5, 8, 0, 0, 0);
      // Load coincident with tick, oversized load clamps, reset beats load.
      tbl[17] = mk(0, 1, 1, 1, 4'd7,  7, 4, 8, 0, 0, 1);
      tbl[18] = mk(0, 0, 1, 1, 4'd15, 7, 7, 7, 0, 0, 0);
      tbl[19] = mk(1, 0, 1, 1, 4'd3,  9, 9, 9, 0, 0, 0);
      tbl[20] = mk(0, 0, 1, 0, 4'd0,  0, 0, 5, 0, 0, 0);

      @(negedge clock);
      do_reset();

      for (int i = 0; i < 21; i++) begin
         reset = tbl[i].rst; enable = tbl[i].en; up = tbl[i].upd;
         load = tbl[i].ld; load_value = tbl[i].lv;
         #1;
         chk($sformatf("vec%0d_count_wrap", i), int'(cnt[0]), tbl[i].ea);
         chk($sformatf("vec%0d_count_sat", i), int'(cnt[1]), tbl[i].eb);
         chk($sformatf("vec%0d_count_pre", i), int'(cnt[2]), tbl[i].ec);
         chk($sformatf("vec%0d_carry_wrap", i), int'(carry_v[0]), int'(tbl[i].ca));
         chk($sformatf("vec%0d_carry_sat", i), int'(carry_v[1]), int'(tbl[i].cb));
         chk($sformatf("vec%0d_tick_pre", i), int'(tick_v[2]), int'(tbl[i].tc));
         finish_cycle();
      end
      reset = 1'b0; load = 1'b0;

      // Two idle cycles mid-period stretch the prescale period by exactly two.
      do_reset();
      begin
         bit en_seq[6] = '{1, 0, 0, 1, 1, 1};
         bit tk_seq[6] = '{0, 0, 0, 0, 1, 0};
         for (int i = 0; i < 6; i++) begin
            enable = en_seq[i]; up = 1'b1;
            #1;
            chk($sformatf("stretch%0d_tick", i), int'(tick_v[2]), int'(tk_seq[i]));
            chk($sformatf("stretch%0d_count", i), int'(cnt[2]), (i < 5) ? 5 : 6);
            finish_cycle();
         end
      end

      // Cascade: two decades form a BCD 00..99 counter, carries together at 99.
      do_reset();
      for (int k = 0; k <= 100; k++) begin
         enable = 1'b1; up = 1'b1; load = 1'b0;
         #1;
         chk($sformatf("bcd%0d_lo", k), int'(cnt[3]), k % 10);
         chk($sformatf("bcd%0d_hi", k), int'(cnt[4]), (k / 10) % 10);
         chk($sformatf("bcd%0d_carry_lo", k), int'(carry_v[3]), int'((k % 10) == 9));
         chk($sformatf("bcd%0d_carry_hi", k), int'(carry_v[4]), int'(k == 99));
         finish_cycle();
      end

      // Randomised traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         reset      = ($urandom_range(99) < 2);
         enable     = ($urandom_range(99) < 70);
         load       = ($urandom_range(99) < 5);
         load_value = 4'($urandom_range(15));
         if ($urandom_range(99) < 15) up = ~up;
         #1;
         finish_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
